// File: rtl/dsp_simd_add.sv
// -----------------------------------------------------------------------------
// dsp_simd_add
//
// Lane-parallel (SIMD) two-operand adder modelled on the DSP-slice ALU.
// Packs 1, 2 or 3 independent WIDTH-bit unsigned additions into one 48-bit
// datapath. Each lane produces a wrapped sum and its own carry-out. No carry
// ever crosses from one lane into the next.
//
// Parameters:
//   WIDTH  bits per lane (LANES=1: 1..48, LANES=2: 1..24, LANES=3: 1..12)
//   LANES  number of independent lanes (1, 2 or 3)
//
// Ports:
//   clock  in   1            clock; only used when the output register exists
//   reset  in   1            asynchronous, active-low reset
//   a      in   LANES*WIDTH  operand A; lane i at [i*WIDTH +: WIDTH]
//   b      in   LANES*WIDTH  operand B; same packing as a
//   y      out  LANES*WIDTH  per-lane wrapped sums; same packing as a
//   co     out  LANES        per-lane unsigned carry-out; bit i is lane i
//
// Build option:
//   DSP_SIMD_ADD_PREG_EN  When defined, adds one output register stage
//                         (PREG equivalent), giving a latency of 1 cycle.
//                         When undefined, y/co are combinational from a/b
//                         and are forced to 0 while reset is low.
// -----------------------------------------------------------------------------
module dsp_simd_add #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic [LANES*WIDTH-1:0] y,
    output logic [LANES-1:0]       co
);

    // Segment width of the 48-bit ALU: ONE48, TWO24 or FOUR12 carry breaks.
    localparam int SEG_W = (LANES == 1) ? 48 : (LANES == 2) ? 24 : 12;
    localparam int N_SEG = 48 / SEG_W;
    localparam int SUM_W = SEG_W + 1;

    generate
        if (LANES < 1 || LANES > 3) begin : g_bad_lanes
            $error("dsp_simd_add: LANES must be 1, 2 or 3 (got %0d)", LANES);
        end
        if (WIDTH < 1 || WIDTH > SEG_W) begin : g_bad_width
            $error("dsp_simd_add: WIDTH %0d out of range 1..%0d for LANES=%0d",
                   WIDTH, SEG_W, LANES);
        end
    endgenerate

    logic [47:0]            a_ext;
    logic [47:0]            b_ext;
    logic [N_SEG*SUM_W-1:0] seg_sum;
    logic [LANES*WIDTH-1:0] sum_y;
    logic [LANES-1:0]       sum_co;

    // Zero-extend every lane into the low bits of its segment. Segments
    // without a lane (the top 12 bits in 3-lane mode) stay tied to 0.
    // NOTE: every variable written in always_comb gets a full default first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        for (int l = 0; l < LANES; l++) begin
            a_ext[l*SEG_W +: WIDTH] = a[l*WIDTH +: WIDTH];
            b_ext[l*SEG_W +: WIDTH] = b[l*WIDTH +: WIDTH];
        end
    end

    // Segment-wise add: each segment gets its own one-bit-wider adder, so a
    // segment carry is kept locally and never ripples into the next segment.
    always_comb begin
        seg_sum = '0;
        for (int s = 0; s < N_SEG; s++) begin
            seg_sum[s*SUM_W +: SUM_W] = {1'b0, a_ext[s*SEG_W +: SEG_W]}
                                      + {1'b0, b_ext[s*SEG_W +: SEG_W]};
        end
    end

    // The lane sum is the low WIDTH bits of its segment; the lane carry is
    // bit WIDTH. When WIDTH equals SEG_W that bit is the segment carry.
    always_comb begin
        sum_y  = '0;
        sum_co = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_y[l*WIDTH +: WIDTH] = seg_sum[l*SUM_W +: WIDTH];
            sum_co[l]               = seg_sum[l*SUM_W + WIDTH];
        end
    end

    // Upper segment bits above WIDTH (and the idle top segment) are never
    // routed to an output; fold them here so they read as intentionally dead.
    logic unused_seg;
    assign unused_seg = ^seg_sum;

`ifdef DSP_SIMD_ADD_PREG_EN
    logic [LANES*WIDTH-1:0] y_d;
    logic [LANES*WIDTH-1:0] y_q;
    logic [LANES-1:0]       co_d;
    logic [LANES-1:0]       co_q;

    always_comb begin
        y_d  = sum_y;
        co_d = sum_co;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            y_q  <= '0;
            co_q <= '0;
        end else begin
            y_q  <= y_d;
            co_q <= co_d;
        end
    end

    assign y  = y_q;
    assign co = co_q;
`else
    // Purely combinational build: the clock has no role.
    logic unused_clock;
    assign unused_clock = clock;

    // Reset gates the outputs directly; there is no state to clear.
    always_comb begin
        y  = reset ? sum_y  : '0;
        co = reset ? sum_co : '0;
    end
`endif

endmodule

// File: tb/tb_dsp_simd_add.sv
// -----------------------------------------------------------------------------
// tb_dsp_simd_add
//
// Self-checking bench for dsp_simd_add. Six instances cover the legal
// (LANES, WIDTH) corners 1/8, 1/32, 2/24, 3/12, 1/48 and 3/5, all sharing one
// clock and reset. Expected results come from a per-lane arithmetic model.
// Inputs change on the falling edge and outputs are sampled 1 time unit after
// the rising edge, which is valid for both the combinational build and the
// registered (DSP_SIMD_ADD_PREG_EN) build.
// -----------------------------------------------------------------------------
module tb_dsp_simd_add;

    localparam int N = 6;
    localparam int LN [N] = '{1, 1, 2, 3, 1, 3};
    localparam int WD [N] = '{8, 32, 24, 12, 48, 5};

    logic        clk;
    logic        rst_n;
    logic [47:0] a_v [N];
    logic [47:0] b_v [N];
    // obs[k] = {co zero-extended to 3 bits, y zero-extended to 48 bits}
    logic [50:0] obs [N];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        logic [LN[k]*WD[k]-1:0] y_w;
        logic [LN[k]-1:0]       co_w;

        dsp_simd_add #(
            .WIDTH (WD[k]),
            .LANES (LN[k])
        ) u_dut (
            .clock (clk),
            .reset (rst_n),
            .a     (a_v[k][LN[k]*WD[k]-1:0]),
            .b     (b_v[k][LN[k]*WD[k]-1:0]),
            .y     (y_w),
            .co    (co_w)
        );

        assign obs[k] = {3'(co_w), 48'(y_w)};
    end

    // Behavioural reference: each lane is an independent unsigned addition.
    function automatic logic [50:0] model(input logic [47:0] a, input logic [47:0] b,
                                          input int lanes, input int width);
        logic [50:0]     r;
        longint unsigned mask;
        longint unsigned ai;
        longint unsigned bi;
        longint unsigned sum;
        r    = '0;
        mask = (64'd1 << width) - 64'd1;
        for (int i = 0; i < lanes; i++) begin
            ai  = (64'(a) >> (i * width)) & mask;
            bi  = (64'(b) >> (i * width)) & mask;
            sum = ai + bi;
            r[47:0]  = r[47:0] | 48'((sum & mask) << (i * width));
            r[48+i]  = ((sum >> width) != 64'd0);
        end
        return r;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic test_reset();
        logic [50:0] exp;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            a_v[k] = 48'hA5A5_5A5A_F0F0;
            b_v[k] = 48'h1234_5678_9ABC;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs[k] !== 51'd0) begin
                failures++;
                $display("FAIL reset_hold inst=%0d got=%h expected=%h", k, obs[k], 51'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
`ifdef DSP_SIMD_ADD_PREG_EN
            exp = '0;
`else
            exp = model(a_v[k], b_v[k], LN[k], WD[k]);
`endif
            checks++;
            if (obs[k] !== exp) begin
                failures++;
                $display("FAIL reset_release inst=%0d got=%h expected=%h", k, obs[k], exp);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            exp = model(a_v[k], b_v[k], LN[k], WD[k]);
            checks++;
            if (obs[k] !== exp) begin
                failures++;
                $display("FAIL reset_first_edge inst=%0d got=%h expected=%h", k, obs[k], exp);
            end
        end
    endtask

    task automatic test_directed();
        logic [50:0] exp [N];
        @(negedge clk);
        a_v[0] = 48'h0000_0000_00FF;           b_v[0] = 48'h0000_0000_0010;
        exp[0] = {3'b001, 48'h0000_0000_000F};
        a_v[1] = 48'h0000_0000_0001;           b_v[1] = 48'h0000_FFFF_0001;
        exp[1] = {3'b000, 48'h0000_FFFF_0002};
        a_v[2] = {24'd23, 24'hFFFFFF};         b_v[2] = {24'd7, 24'h000010};
        exp[2] = {3'b001, 24'd30, 24'h00000F};
        a_v[3] = {12'h000, 12'd25, 12'hFE9, 12'h001};
        b_v[3] = {12'h000, 12'd7,  12'hFF9, 12'hFF0};
        exp[3] = {3'b010, 12'h000, 12'd32, 12'hFE2, 12'hFF1};
        a_v[4] = 48'hFFFF_FFFF_FFFF;           b_v[4] = 48'h0000_0000_0001;
        exp[4] = {3'b001, 48'h0};
        a_v[5] = {33'd0, 5'd31, 5'd0, 5'd31};  b_v[5] = {33'd0, 5'd31, 5'd0, 5'd1};
        exp[5] = {3'b101, 33'd0, 5'd30, 5'd0, 5'd0};
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs[k] !== exp[k]) begin
                failures++;
                $display("FAIL directed inst=%0d got=%h expected=%h", k, obs[k], exp[k]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [50:0] exp;
        logic [47:0] ones;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                ones = '0;
                for (int i = 0; i < LN[k] * WD[k]; i++) ones[i] = 1'b1;
                if (pass == 0) begin
                    // All-ones plus one in every lane.
                    a_v[k] = ones;
                    b_v[k] = '0;
                    for (int l = 0; l < LN[k]; l++) b_v[k][l*WD[k]] = 1'b1;
                end else begin
                    a_v[k] = '0;
                    b_v[k] = '0;
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                exp = '0;
                if (pass == 0) begin
                    for (int l = 0; l < LN[k]; l++) exp[48+l] = 1'b1;
                end
                checks++;
                if (obs[k] !== exp) begin
                    failures++;
                    $display("FAIL boundary%0d inst=%0d got=%h expected=%h",
                             pass, k, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [50:0] exp;
        int          bad;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                a_v[k] = rand48();
                b_v[k] = rand48();
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                exp = model(a_v[k], b_v[k], LN[k], WD[k]);
                checks++;
                if (obs[k] !== exp) begin
                    failures++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random iter=%0d inst=%0d a=%h b=%h got=%h expected=%h",
                                 n, k, a_v[k], b_v[k], obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [50:0] exp;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            a_v[k] = rand48() | 48'h1;
            b_v[k] = rand48() | 48'h1;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs[k] !== 51'd0) begin
                failures++;
                $display("FAIL reset_mid inst=%0d got=%h expected=%h", k, obs[k], 51'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            exp = model(a_v[k], b_v[k], LN[k], WD[k]);
            checks++;
            if (obs[k] !== exp) begin
                failures++;
                $display("FAIL reset_resume inst=%0d got=%h expected=%h", k, obs[k], exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end
        test_reset();
        test_directed();
        test_boundaries();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
